// File: rtl/pbm_pkt_queue_if.sv
// rtl/pbm_pkt_queue_if.sv - write/read stream bundle of the packet buffer manager
interface pbm_pkt_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_wr_valid;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_wr_last;
  logic                  i_wr_error;
  logic                  o_wr_ready;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_last;
  logic                  i_rd_ready;

  modport master (
    output i_wr_valid, i_wr_data, i_wr_last, i_wr_error, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_wr_last, i_wr_error, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last
  );
endinterface

// File: rtl/pbm_pkt_queue.sv
// rtl/pbm_pkt_queue.sv - packet buffer with speculative write, commit/rollback and packet-framed read; PBM_PKT_STATS_EN adds commit/drop counters
module pbm_pkt_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int MAX_PKTS_LOG2 = 5,
  parameter int HEADROOM      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pbm_pkt_queue_if.slave         bus,
  output logic                   o_pkt_avail,
  output logic [ADDR_WIDTH:0]    o_pkt_len,
  output logic [ADDR_WIDTH:0]    o_usage,
  output logic [MAX_PKTS_LOG2:0] o_pkt_count
`ifdef PBM_PKT_STATS_EN
  ,
  output logic [15:0]            o_stat_commits,
  output logic [15:0]            o_stat_drops
`endif
);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int DESC_DEPTH = 1 << MAX_PKTS_LOG2;
  localparam int PW         = ADDR_WIDTH + 1;
  localparam int CW         = MAX_PKTS_LOG2 + 1;
  localparam logic [PW-1:0] STALL_LEVEL     = PW'(DEPTH - HEADROOM);
  localparam logic [CW-1:0] DESC_FULL_LEVEL = CW'(DESC_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT} rd_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         desc_mem [DESC_DEPTH];

  logic [PW-1:0]         head_reserve, head_commit, tail, len_cnt, rd_cnt;
  logic [CW-1:0]         desc_wr, desc_rd;
  rd_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_last_q, rd_valid;
  logic                  wr_ready, wr_accept, wr_commit, wr_rollback;
  logic                  rd_hs, rd_pop, rd_load, words_ready, load_next_pkt, load_last;
  logic [PW-1:0]         load_idx, load_len;
  logic [MAX_PKTS_LOG2-1:0] desc_rd_idx, desc_nx_idx;

  // Pointer differences are modular, so the wrap bit keeps full/empty distinct.
  assign o_usage     = head_reserve - tail;
  assign o_pkt_count = desc_wr - desc_rd;
  assign o_pkt_avail = (o_pkt_count != '0);
  assign desc_rd_idx = desc_rd[MAX_PKTS_LOG2-1:0];
  assign desc_nx_idx = desc_rd_idx + MAX_PKTS_LOG2'(1);
  assign o_pkt_len   = o_pkt_avail ? desc_mem[desc_rd_idx] : '0;

  assign wr_ready    = (o_usage < STALL_LEVEL) && (o_pkt_count != DESC_FULL_LEVEL);
  assign wr_accept   = bus.i_wr_valid && wr_ready;
  assign wr_commit   = wr_accept && bus.i_wr_last && !bus.i_wr_error;
  assign wr_rollback = wr_accept && bus.i_wr_last && bus.i_wr_error;

  assign rd_valid    = (state_q == S_OUT);
  assign rd_hs       = rd_valid && bus.i_rd_ready;
  assign rd_pop      = rd_hs && rd_last_q;
  assign words_ready = (tail != head_commit);

  // A word loaded right after the head packet's last word belongs to the next descriptor.
  assign load_next_pkt = rd_valid && rd_last_q;
  assign load_len      = load_next_pkt ? desc_mem[desc_nx_idx] : desc_mem[desc_rd_idx];
  assign load_idx      = load_next_pkt ? PW'(1) : rd_cnt + PW'(1);
  assign load_last     = (load_idx == load_len);

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_rd_valid = rd_valid;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_last  = rd_last_q;

  // Write-side pointers: reserve speculatively, publish on commit, rewind on rollback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reserve <= '0;
      head_commit  <= '0;
      len_cnt      <= '0;
      desc_wr      <= '0;
    end else if (wr_accept) begin
      if (wr_rollback) begin
        head_reserve <= head_commit;
        len_cnt      <= '0;
      end else begin
        head_reserve <= head_reserve + PW'(1);
        if (wr_commit) begin
          head_commit <= head_reserve + PW'(1);
          desc_wr     <= desc_wr + CW'(1);
          len_cnt     <= '0;
        end else begin
          len_cnt <= len_cnt + PW'(1);
        end
      end
    end
  end

  // Packet RAM write port; a rolled-back beat lands beyond head_commit and is never read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[head_reserve[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
    end
  end

  // Descriptor FIFO storage; only the pointers need clearing.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      desc_mem[desc_wr[MAX_PKTS_LOG2-1:0]] <= len_cnt + PW'(1);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Read FSM next state and RAM fetch strobe; a handshake with more data prefetches.
  always_comb begin
    state_d = state_q;
    rd_load = 1'b0;
    unique case (state_q)
      S_IDLE:  if (words_ready) state_d = S_FETCH;
      S_FETCH: begin
        rd_load = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (rd_hs) begin
          if (words_ready) rd_load = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register, tail pointer, per-packet word position and descriptor pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail      <= '0;
      rd_cnt    <= '0;
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
      desc_rd   <= '0;
    end else begin
      if (rd_load) begin
        rd_data_q <= mem[tail[ADDR_WIDTH-1:0]];
        rd_last_q <= load_last;
        tail      <= tail + PW'(1);
        rd_cnt    <= load_idx;
      end else if (rd_pop) begin
        rd_cnt <= '0;
      end
      if (rd_pop) desc_rd <= desc_rd + CW'(1);
    end
  end

`ifdef PBM_PKT_STATS_EN
  // Saturating counts of committed and dropped packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_commits <= '0;
      o_stat_drops   <= '0;
    end else begin
      if (wr_commit && (o_stat_commits != 16'hFFFF)) o_stat_commits <= o_stat_commits + 16'd1;
      if (wr_rollback && (o_stat_drops != 16'hFFFF)) o_stat_drops <= o_stat_drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pbm_pkt_queue.sv
// tb/tb_pbm_pkt_queue.sv - self-checking bench for pbm_pkt_queue
module tb_pbm_pkt_queue;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int MPL = 2;
  localparam int HR  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pbm_pkt_queue_if #(.DATA_WIDTH(DW)) bus ();

  logic          pkt_avail;
  logic [AW:0]   pkt_len;
  logic [AW:0]   usage;
  logic [MPL:0]  pkt_count;

  pbm_pkt_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKTS_LOG2(MPL), .HEADROOM(HR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_pkt_avail(pkt_avail),
    .o_pkt_len(pkt_len),
    .o_usage(usage),
    .o_pkt_count(pkt_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: committed words in read order tagged with their last flag,
  // committed packet lengths, and the packet currently being written.
  logic [DW:0]   exp_q[$];
  int            len_q[$];
  logic [DW-1:0] cur_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_commit();
    logic lb;
    len_q.push_back(cur_q.size());
    foreach (cur_q[i]) begin
      lb = (i == cur_q.size() - 1);
      exp_q.push_back({lb, cur_q[i]});
    end
    cur_q.delete();
  endtask

  task automatic model_clear();
    exp_q.delete();
    len_q.delete();
    cur_q.delete();
  endtask

  task automatic check_reset_state(input string sfx);
    check({"rst_wr_ready", sfx}, 32'(bus.o_wr_ready), 32'd1);
    check({"rst_rd_valid", sfx}, 32'(bus.o_rd_valid), 32'd0);
    check({"rst_rd_data", sfx},  32'(bus.o_rd_data),  32'd0);
    check({"rst_rd_last", sfx},  32'(bus.o_rd_last),  32'd0);
    check({"rst_pkt_avail", sfx}, 32'(pkt_avail), 32'd0);
    check({"rst_pkt_len", sfx},  32'(pkt_len),   32'd0);
    check({"rst_usage", sfx},    32'(usage),     32'd0);
    check({"rst_pkt_count", sfx}, 32'(pkt_count), 32'd0);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic wr_beat(input logic [DW-1:0] d, input logic l, input logic e);
    int n;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = d;
    bus.i_wr_last  = l;
    bus.i_wr_error = e;
    n = 0;
    while (bus.o_wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wr_ready_timeout", 32'(bus.o_wr_ready), 32'd1);
    @(posedge clk);
    if (!l) cur_q.push_back(d);
    else if (!e) begin
      cur_q.push_back(d);
      model_commit();
    end else cur_q.delete();
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    bus.i_wr_last  = 1'b0;
    bus.i_wr_error = 1'b0;
  endtask

  task automatic wr_pkt(input int n, input logic [DW-1:0] base, input logic err);
    for (int i = 0; i < n; i++) wr_beat(base + DW'(i), (i == n - 1), err && (i == n - 1));
  endtask

  // mode 0: ready held high, 1: ready toggles each cycle, 2: random ready.
  // strict demands a valid word on every cycle (back-to-back throughput).
  task automatic rd_words(input int nwords, input int mode, input bit strict);
    int  got = 0;
    int  cyc = 0;
    bit  r = 1'b0;
    while (got < nwords && cyc < 600) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = ~r;
      else                r = 1'($urandom_range(0, 1));
      bus.i_rd_ready = r;
      if (bus.o_rd_valid === 1'b1) begin
        check("rd_data", 32'(bus.o_rd_data), 32'(exp_q[0][DW-1:0]));
        check("rd_last", 32'(bus.o_rd_last), 32'(exp_q[0][DW]));
        check("pkt_len_head", 32'(pkt_len), 32'(len_q[0]));
        if (r) begin
          if (exp_q[0][DW]) void'(len_q.pop_front());
          void'(exp_q.pop_front());
          got++;
        end
      end else if (strict) begin
        check("rd_valid_b2b", 32'(bus.o_rd_valid), 32'd1);
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_rd_ready = 1'b0;
    if (got < nwords) check("rd_words_timeout", 32'(got), 32'(nwords));
  endtask

  initial begin
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_wr_last  = 1'b0;
    bus.i_wr_error = 1'b0;
    bus.i_rd_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_state("");
    rst_n = 1'b1;
    @(negedge clk);

    // 4-word packet A0..A3: descriptor, latency, 1 word/clk readout.
    wr_pkt(4, 16'h00A0, 1'b0);
    check("a_pkt_count", 32'(pkt_count), 32'd1);
    check("a_pkt_avail", 32'(pkt_avail), 32'd1);
    check("a_pkt_len", 32'(pkt_len), 32'd4);
    check("a_usage", 32'(usage), 32'd4);
    check("a_valid_lat0", 32'(bus.o_rd_valid), 32'd0);
    @(negedge clk);
    check("a_valid_lat1", 32'(bus.o_rd_valid), 32'd0);
    @(negedge clk);
    check("a_valid_lat2", 32'(bus.o_rd_valid), 32'd1);
    check("a_usage_fetched", 32'(usage), 32'd3);
    rd_words(4, 0, 1'b1);
    check("a_pkt_count_end", 32'(pkt_count), 32'd0);
    check("a_pkt_avail_end", 32'(pkt_avail), 32'd0);
    check("a_usage_end", 32'(usage), 32'd0);
    check("a_valid_end", 32'(bus.o_rd_valid), 32'd0);

    // 3 words then an errored last beat: everything rolls back.
    wr_pkt(4, 16'h00B0, 1'b1);
    check("b_usage", 32'(usage), 32'd0);
    check("b_pkt_avail", 32'(pkt_avail), 32'd0);
    repeat (4) @(negedge clk);
    check("b_no_read", 32'(bus.o_rd_valid), 32'd0);

    // Commit P1, abort P2: only P1 remains readable.
    wr_pkt(2, 16'h00C0, 1'b0);
    wr_pkt(3, 16'h00D0, 1'b1);
    check("c_pkt_count", 32'(pkt_count), 32'd1);
    check("c_pkt_len", 32'(pkt_len), 32'd2);
    check("c_usage", 32'(usage), 32'd1);
    rd_words(2, 0, 1'b0);
    check("c_usage_end", 32'(usage), 32'd0);
    repeat (3) @(negedge clk);
    check("c_no_more", 32'(bus.o_rd_valid), 32'd0);

    // Headroom stall at usage 14, then drain and finish across the pointer wrap.
    wr_pkt(13, 16'h0100, 1'b0);
    repeat (3) @(negedge clk);
    check("d_usage12", 32'(usage), 32'd12);
    check("d_ready12", 32'(bus.o_wr_ready), 32'd1);
    wr_beat(16'h0200, 1'b0, 1'b0);
    wr_beat(16'h0201, 1'b0, 1'b0);
    check("d_usage14", 32'(usage), 32'd14);
    check("d_ready14", 32'(bus.o_wr_ready), 32'd0);
    rd_words(13, 2, 1'b0);
    check("d_usage_partial", 32'(usage), 32'd2);
    check("d_ready_after", 32'(bus.o_wr_ready), 32'd1);
    wr_beat(16'h0202, 1'b1, 1'b0);
    rd_words(3, 0, 1'b0);
    check("d_usage_end", 32'(usage), 32'd0);

    // Descriptor FIFO full blocks writes though RAM has room.
    for (int i = 0; i < 4; i++) wr_pkt(1, 16'h0300 + DW'(i), 1'b0);
    repeat (3) @(negedge clk);
    check("e_pkt_count", 32'(pkt_count), 32'd4);
    check("e_ready_full", 32'(bus.o_wr_ready), 32'd0);
    check("e_usage", 32'(usage), 32'd3);
    rd_words(1, 0, 1'b0);
    check("e_ready_after_pop", 32'(bus.o_wr_ready), 32'd1);
    check("e_pkt_count_pop", 32'(pkt_count), 32'd3);
    rd_words(3, 0, 1'b0);

    // Randomized batches with idle-cycle noise on last/error.
    for (int it = 0; it < 20; it++) begin
      int npk;
      bus.i_wr_last  = 1'($urandom_range(0, 1));
      bus.i_wr_error = 1'($urandom_range(0, 1));
      bus.i_wr_data  = DW'($urandom);
      @(negedge clk);
      bus.i_wr_last  = 1'b0;
      bus.i_wr_error = 1'b0;
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        int  plen;
        bit  perr;
        plen = $urandom_range(1, 4);
        perr = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < plen; b++)
          wr_beat(DW'($urandom), (b == plen - 1), perr && (b == plen - 1));
      end
      check("r_pkt_count", 32'(pkt_count), 32'(len_q.size()));
      rd_words(exp_q.size(), 2, 1'b0);
      check("r_usage_end", 32'(usage), 32'd0);
      check("r_pkt_count_end", 32'(pkt_count), 32'd0);
    end

    // Ready toggling during a 6-word packet, then reset mid-read and mid-packet.
    wr_pkt(6, 16'h0400, 1'b0);
    rd_words(3, 1, 1'b0);
    wr_beat(16'h0500, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_state("_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
